rwt_dac_burst_sched: RTL and testbench
======================================

Name: rwt_dac_burst_sched

Overview:
- Timed-transmit scheduler in the DAC clock domain.
- Consumes the tagged sample stream produced by the tag-extract stage. A TX_TIME tag arms a burst; the burst's samples are released to the DAC data register starting exactly at the programmed sample time and ending at the last beat.
- Owns the free-running DAC sample-time counter.
- Reports underflow, late bursts and protocol errors.

Parameters:
- TIME_WIDTH, 64, width of the sample-time counter and of the start-time tag payload.
- TAG_TX_TIME, 7'h01, tag_type value that carries a start time.

Ports:
- dac_clk  in  1  single clock for the whole block.
- dac_rst  in  1  synchronous, active-high reset.
- dac_strobe  in  1  one pulse per DAC sample slot (the DAC's channel-0 valid).
- s_valid  in  1  input stream valid.
- s_ready  out  1  input stream ready.
- s_data  in  64  four 16-bit samples, or the tag payload.
- s_tag_valid  in  1  beat is a tag, not samples.
- s_tag_type  in  7  tag type.
- s_last  in  1  last beat of the burst.
- cfg_enable  in  1  scheduler enable. When 0: goes to IDLE and outputs zero.
- cfg_drop_late  in  1  1 = discard late bursts; 0 = send late bursts immediately.
- cfg_timed_only  in  1  1 = untagged samples in IDLE are discarded.
- cfg_time_load  in  1  pulse: load the time counter.
- cfg_time_value  in  TIME_WIDTH  value loaded by cfg_time_load.
- sample_time  out  TIME_WIDTH  current sample time.
- dac_data_out  out  64  registered samples to the DAC.
- busy  out  1  state != IDLE.
- underflow  out  1  one-cycle pulse.
- late  out  1  one-cycle pulse.
- proto_err  out  1  one-cycle pulse.
- underflow_count  out  32  statistics counter (see Optional Feature).
- late_count  out  32  statistics counter (see Optional Feature).
- burst_count  out  32  statistics counter (see Optional Feature).

Behaviour:
- Reset values: all outputs 0, sample_time 0, state IDLE.
- sample_time:
  - Increments by 1 on each dac_strobe and wraps modulo 2^TIME_WIDTH.
  - cfg_time_load has priority over the increment; the loaded value is visible the next cycle.
- Handshake:
  - A beat transfers when s_valid & s_ready.
  - s_ready is combinational from state, s_* and dac_strobe.
- States:
  - IDLE, s_ready=1:
    - Tag beat with type TAG_TX_TIME: latch start_time ← s_data[TIME_WIDTH-1:0], go to WAIT.
    - Any other tag type: consumed and ignored.
    - Sample beat with cfg_timed_only=0: s_ready is gated by dac_strobe. The beat is emitted and the block enters BURST, or stays in IDLE if s_last=1.
    - Sample beat with cfg_timed_only=1: consumed, dropped, proto_err pulses.
  - WAIT, s_ready=0:
    - On dac_strobe with sample_time == start_time: go to BURST; the first sample is taken on that same strobe (s_ready=1 that cycle).
    - If sample_time > start_time (unsigned, checked every cycle), late pulses once:
      - cfg_drop_late=1: go to DROP.
      - cfg_drop_late=0: go to BURST immediately.
  - BURST:
    - s_ready = dac_strobe & ~s_tag_valid.
    - On a strobe with a sample beat: dac_data_out ← s_data (1-cycle latency). s_last=1 → IDLE.
    - On a strobe with no valid beat: underflow pulses, dac_data_out ← 0, state stays BURST.
    - Tag beat while in BURST: consumed (s_ready forced 1), proto_err pulses, go to IDLE.
  - DROP:
    - s_ready=1; beats are discarded until a beat with s_last=1, then IDLE.
- Outside BURST, dac_data_out ← 0 on every strobe.
- cfg_enable=0:
  - Forces IDLE next cycle and s_ready=0.
  - Output goes to 0 on the next strobe.
  - sample_time keeps counting.
- Reset mid-burst: immediate return to IDLE with zero output; partial-burst input is not flushed.
- Simultaneous cases:
  - cfg_time_load in WAIT: the comparison uses the loaded value from the next cycle.
  - Strobe on the same cycle as the start-time match: the start beat is emitted.

Optional Feature:
- Macro: RWT_DAC_SCHED_STATS_EN.
- Defined:
  - underflow_count, late_count and burst_count are 32-bit saturating counters, cleared by dac_rst.
  - burst_count increments on each entry to BURST.
- Undefined: the three ports are tied to 0 and no counter logic is synthesized.

Decomposition:
- Package rwt_dac_sched_pkg holds:
  - state encoding (IDLE=0, WAIT=1, BURST=2, DROP=3);
  - TAG_TX_TIME default;
  - counter width constant (32).
- Sub-module rwt_dac_sched_timer: sample_time counter with load and wrap.

Test Plan:
- Strobe every 4 cycles; tag TX_TIME=100; 3 sample beats (last on the 3rd) → dac_data_out shows beat0 one cycle after the strobe where sample_time==100, then beat1 and beat2; then 0; burst_count=1.
- Same, but s_valid drops for the 2nd sample slot → underflow pulse, output 0 for that slot, burst resumes, late=0.
- Tag TX_TIME=10 while sample_time=50, cfg_drop_late=1, 4-beat burst → late pulse; all 4 beats consumed; output stays 0; IDLE.
- Same with cfg_drop_late=0 → late pulse; the 4 beats are output on the next 4 strobes.
- Tag beat arriving mid-BURST → proto_err pulse; IDLE; the following TX_TIME tag is accepted normally.
- cfg_time_load value 2^64-2 with 3 strobes → sample_time reads 2^64-1, then 0, then 1; a tag with start time 0 fires on the wrapped strobe.

Source files
------------

// File: rtl/rwt_dac_sched_pkg.sv
// Shared types and constants for the DAC timed-transmit scheduler.
package rwt_dac_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_DROP  = 2'd3
  } sched_state_t;

  localparam logic [6:0]  TAG_TX_TIME_DEFAULT = 7'h01;
  localparam int unsigned CNT_WIDTH           = 32;

endpackage

// File: rtl/rwt_dac_sched_timer.sv
// Free-running DAC sample-time counter: +1 per strobe, wraps, load wins.
module rwt_dac_sched_timer #(
  parameter int unsigned TIME_WIDTH = 64
) (
  input  logic                  dac_clk,
  input  logic                  dac_rst,
  input  logic                  dac_strobe,
  input  logic                  time_load,
  input  logic [TIME_WIDTH-1:0] time_value,
  output logic [TIME_WIDTH-1:0] sample_time
);

  // Sample-time register; the load value appears the cycle after the pulse.
  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      sample_time <= '0;
    end else if (time_load) begin
      sample_time <= time_value;
    end else if (dac_strobe) begin
      sample_time <= sample_time + 1'b1;
    end
  end

endmodule

// File: rtl/rwt_dac_burst_sched.sv
// Timed-transmit burst scheduler in the DAC clock domain.
// Optional statistics counters: define RWT_DAC_SCHED_STATS_EN.
module rwt_dac_burst_sched
  import rwt_dac_sched_pkg::*;
#(
  parameter int unsigned TIME_WIDTH  = 64,
  parameter logic [6:0]  TAG_TX_TIME = TAG_TX_TIME_DEFAULT
) (
  input  logic                  dac_clk,
  input  logic                  dac_rst,
  input  logic                  dac_strobe,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [63:0]           s_data,
  input  logic                  s_tag_valid,
  input  logic [6:0]            s_tag_type,
  input  logic                  s_last,
  input  logic                  cfg_enable,
  input  logic                  cfg_drop_late,
  input  logic                  cfg_timed_only,
  input  logic                  cfg_time_load,
  input  logic [TIME_WIDTH-1:0] cfg_time_value,
  output logic [TIME_WIDTH-1:0] sample_time,
  output logic [63:0]           dac_data_out,
  output logic                  busy,
  output logic                  underflow,
  output logic                  late,
  output logic                  proto_err,
  output logic [CNT_WIDTH-1:0]  underflow_count,
  output logic [CNT_WIDTH-1:0]  late_count,
  output logic [CNT_WIDTH-1:0]  burst_count
);

  sched_state_t          state, state_nxt;
  logic [TIME_WIDTH-1:0] start_time;
  logic                  start_ld;
  logic                  emit;
  logic                  evt_uf, evt_late, evt_perr;
  logic                  tag_tx;

  rwt_dac_sched_timer #(.TIME_WIDTH(TIME_WIDTH)) u_timer (
    .dac_clk     (dac_clk),
    .dac_rst     (dac_rst),
    .dac_strobe  (dac_strobe),
    .time_load   (cfg_time_load),
    .time_value  (cfg_time_value),
    .sample_time (sample_time)
  );

  assign tag_tx = s_tag_valid && (s_tag_type == TAG_TX_TIME);
  assign busy   = (state != ST_IDLE);

  // Next state, handshake and event decode.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    start_ld  = 1'b0;
    emit      = 1'b0;
    evt_uf    = 1'b0;
    evt_late  = 1'b0;
    evt_perr  = 1'b0;
    if (!cfg_enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          s_ready = (s_tag_valid || cfg_timed_only) ? 1'b1 : dac_strobe;
          if (s_valid && s_ready) begin
            if (s_tag_valid) begin
              if (tag_tx) begin
                start_ld  = 1'b1;
                state_nxt = ST_WAIT;
              end
            end else if (cfg_timed_only) begin
              evt_perr = 1'b1;
            end else begin
              emit = 1'b1;
              if (!s_last) state_nxt = ST_BURST;
            end
          end
        end
        ST_WAIT: begin
          // The matching strobe is already the first burst slot.
          if (dac_strobe && (sample_time == start_time)) begin
            s_ready = 1'b1;
            if (s_valid && s_tag_valid) begin
              evt_perr  = 1'b1;
              state_nxt = ST_IDLE;
            end else if (s_valid) begin
              emit      = 1'b1;
              state_nxt = s_last ? ST_IDLE : ST_BURST;
            end else begin
              evt_uf    = 1'b1;
              state_nxt = ST_BURST;
            end
          end else if (sample_time > start_time) begin
            evt_late  = 1'b1;
            state_nxt = cfg_drop_late ? ST_DROP : ST_BURST;
          end
        end
        ST_BURST: begin
          s_ready = s_tag_valid ? 1'b1 : dac_strobe;
          if (s_valid && s_tag_valid) begin
            evt_perr  = 1'b1;
            state_nxt = ST_IDLE;
          end else if (dac_strobe) begin
            if (s_valid) begin
              emit = 1'b1;
              if (s_last) state_nxt = ST_IDLE;
            end else begin
              evt_uf = 1'b1;
            end
          end
        end
        ST_DROP: begin
          s_ready = 1'b1;
          if (s_valid && s_last) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge dac_clk) begin
    if (dac_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Start-time latch, loaded from an accepted TX_TIME tag.
  always_ff @(posedge dac_clk) begin
    if (dac_rst)       start_time <= '0;
    else if (start_ld) start_time <= s_data[TIME_WIDTH-1:0];
  end

  // DAC data register: every strobe writes either the released beat or zero.
  always_ff @(posedge dac_clk) begin
    if (dac_rst)         dac_data_out <= '0;
    else if (dac_strobe) dac_data_out <= emit ? s_data : '0;
  end

  // One-cycle status pulses.
  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      underflow <= 1'b0;
      late      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      underflow <= evt_uf;
      late      <= evt_late;
      proto_err <= evt_perr;
    end
  end

`ifdef RWT_DAC_SCHED_STATS_EN
  logic burst_entry;
  assign burst_entry = (state_nxt == ST_BURST) && (state != ST_BURST);

  // Saturating statistics counters.
  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      underflow_count <= '0;
      late_count      <= '0;
      burst_count     <= '0;
    end else begin
      if (evt_uf && (underflow_count != '1))  underflow_count <= underflow_count + 1'b1;
      if (evt_late && (late_count != '1))     late_count      <= late_count + 1'b1;
      if (burst_entry && (burst_count != '1)) burst_count     <= burst_count + 1'b1;
    end
  end
`else
  assign underflow_count = '0;
  assign late_count      = '0;
  assign burst_count     = '0;
`endif

endmodule

// File: tb/tb_rwt_dac_burst_sched.sv
// Table-driven bench for rwt_dac_burst_sched (optionally RWT_DAC_SCHED_STATS_EN).
module tb_rwt_dac_burst_sched;

  logic        dac_clk = 1'b0;
  logic        dac_rst, dac_strobe, s_valid, s_ready, s_tag_valid, s_last;
  logic [63:0] s_data;
  logic [6:0]  s_tag_type;
  logic        cfg_enable, cfg_drop_late, cfg_timed_only, cfg_time_load;
  logic [63:0] cfg_time_value, sample_time, dac_data_out;
  logic        busy, underflow, late, proto_err;
  logic [31:0] underflow_count, late_count, burst_count;

  rwt_dac_burst_sched #(.TIME_WIDTH(64), .TAG_TX_TIME(7'h01)) dut (
    .dac_clk(dac_clk), .dac_rst(dac_rst), .dac_strobe(dac_strobe),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_tag_valid(s_tag_valid), .s_tag_type(s_tag_type), .s_last(s_last),
    .cfg_enable(cfg_enable), .cfg_drop_late(cfg_drop_late),
    .cfg_timed_only(cfg_timed_only), .cfg_time_load(cfg_time_load),
    .cfg_time_value(cfg_time_value), .sample_time(sample_time),
    .dac_data_out(dac_data_out), .busy(busy), .underflow(underflow),
    .late(late), .proto_err(proto_err), .underflow_count(underflow_count),
    .late_count(late_count), .burst_count(burst_count)
  );

  always #5 dac_clk = ~dac_clk;

  typedef struct {
    logic        en, drop, tonly, ld;
    logic [63:0] ldv;
    logic        stb, vld, tag;
    logic [6:0]  ty;
    logic        last;
    logic [63:0] d;
    logic        rdy;
    logic [63:0] q;
    logic        bsy;
    logic [2:0]  fl;   // {underflow, late, proto_err}
    logic [63:0] st;
  } vec_t;

  vec_t vecs[$];
  vec_t v;
  logic c_en, c_dr, c_to;
  int   n_pass = 0;
  int   n_total = 0;

  localparam logic [6:0] TX = 7'h01;

  task automatic add(input logic ld, input logic [63:0] ldv, input logic stb, vld, tag,
                     input logic [6:0] ty, input logic last, input logic [63:0] d,
                     input logic rdy, input logic [63:0] q, input logic bsy,
                     input logic [2:0] fl, input logic [63:0] st);
    vec_t r;
    r.en = c_en; r.drop = c_dr; r.tonly = c_to; r.ld = ld; r.ldv = ldv;
    r.stb = stb; r.vld = vld; r.tag = tag; r.ty = ty; r.last = last; r.d = d;
    r.rdy = rdy; r.q = q; r.bsy = bsy; r.fl = fl; r.st = st;
    vecs.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic en, drop, tonly, ld, input logic [63:0] ldv,
                       input logic stb, vld, tag, input logic [6:0] ty,
                       input logic last, input logic [63:0] d);
    cfg_enable = en; cfg_drop_late = drop; cfg_timed_only = tonly;
    cfg_time_load = ld; cfg_time_value = ldv;
    dac_strobe = stb; s_valid = vld; s_tag_valid = tag; s_tag_type = ty;
    s_last = last; s_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    dac_rst = 1'b1;
    drive(1, 0, 0, 0, '0, 0, 0, 0, '0, 0, '0);
    repeat (3) @(posedge dac_clk);
    #1;
    chk("rst_data", dac_data_out, 64'd0);
    chk("rst_time", sample_time, 64'd0);
    chk("rst_flags", {60'd0, busy, underflow, late, proto_err}, 64'd0);
    chk("rst_counts", {underflow_count, late_count | burst_count}, 64'd0);
    dac_rst = 1'b0;

    c_en = 1; c_dr = 0; c_to = 0;
    // normal burst at 100
    add(1, 98,  0,0,0,'0,0,'0,   0, '0, 0, 3'b000, 98);
    add(0, '0,  0,1,1,TX,0,100,  1, '0, 1, 3'b000, 98);
    add(0, '0,  1,0,0,'0,0,'0,   0, '0, 1, 3'b000, 99);
    add(0, '0,  1,0,0,'0,0,'0,   0, '0, 1, 3'b000, 100);
    add(0, '0,  0,1,0,'0,0,64'hA0A0_0000_1111_2222, 0, '0, 1, 3'b000, 100);
    add(0, '0,  1,1,0,'0,0,64'hA0A0_0000_1111_2222, 1, 64'hA0A0_0000_1111_2222, 1, 3'b000, 101);
    add(0, '0,  0,1,0,'0,0,64'hA1A1_3333_4444_5555, 0, 64'hA0A0_0000_1111_2222, 1, 3'b000, 101);
    add(0, '0,  1,1,0,'0,0,64'hA1A1_3333_4444_5555, 1, 64'hA1A1_3333_4444_5555, 1, 3'b000, 102);
    add(0, '0,  1,1,0,'0,1,64'hA2A2_6666_7777_8888, 1, 64'hA2A2_6666_7777_8888, 0, 3'b000, 103);
    add(0, '0,  1,0,0,'0,0,'0,   1, '0, 0, 3'b000, 104);
    // burst at 106 with a missing second beat
    add(0, '0,  0,1,1,TX,0,106,  1, '0, 1, 3'b000, 104);
    add(0, '0,  1,0,0,'0,0,'0,   0, '0, 1, 3'b000, 105);
    add(0, '0,  1,0,0,'0,0,'0,   0, '0, 1, 3'b000, 106);
    add(0, '0,  1,1,0,'0,0,64'hB0B0_0001_0002_0003, 1, 64'hB0B0_0001_0002_0003, 1, 3'b000, 107);
    add(0, '0,  1,0,0,'0,0,'0,   1, '0, 1, 3'b100, 108);
    add(0, '0,  1,1,0,'0,0,64'hB1B1_0004_0005_0006, 1, 64'hB1B1_0004_0005_0006, 1, 3'b000, 109);
    add(0, '0,  1,1,0,'0,1,64'hB2B2_0007_0008_0009, 1, 64'hB2B2_0007_0008_0009, 0, 3'b000, 110);
    add(0, '0,  1,0,0,'0,0,'0,   1, '0, 0, 3'b000, 111);
    // late burst, dropped
    c_dr = 1;
    add(1, 50,  0,0,0,'0,0,'0,   0, '0, 0, 3'b000, 50);
    add(0, '0,  0,1,1,TX,0,10,   1, '0, 1, 3'b000, 50);
    add(0, '0,  0,0,0,'0,0,'0,   0, '0, 1, 3'b010, 50);
    add(0, '0,  1,1,0,'0,0,64'hC0, 1, '0, 1, 3'b000, 51);
    add(0, '0,  0,1,0,'0,0,64'hC1, 1, '0, 1, 3'b000, 51);
    add(0, '0,  1,1,0,'0,0,64'hC2, 1, '0, 1, 3'b000, 52);
    add(0, '0,  0,1,0,'0,1,64'hC3, 1, '0, 0, 3'b000, 52);
    add(0, '0,  1,0,0,'0,0,'0,   1, '0, 0, 3'b000, 53);
    // late burst, sent immediately
    c_dr = 0;
    add(0, '0,  0,1,1,TX,0,10,   1, '0, 1, 3'b000, 53);
    add(0, '0,  0,0,0,'0,0,'0,   0, '0, 1, 3'b010, 53);
    add(0, '0,  1,1,0,'0,0,64'hD0D0_0000_0000_0000, 1, 64'hD0D0_0000_0000_0000, 1, 3'b000, 54);
    add(0, '0,  1,1,0,'0,0,64'hD1D1_0000_0000_0001, 1, 64'hD1D1_0000_0000_0001, 1, 3'b000, 55);
    add(0, '0,  1,1,0,'0,0,64'hD2D2_0000_0000_0002, 1, 64'hD2D2_0000_0000_0002, 1, 3'b000, 56);
    add(0, '0,  1,1,0,'0,1,64'hD3D3_0000_0000_0003, 1, 64'hD3D3_0000_0000_0003, 0, 3'b000, 57);
    add(0, '0,  1,0,0,'0,0,'0,   1, '0, 0, 3'b000, 58);
    // tag mid-burst, then a normal TX_TIME tag with a time load while waiting
    add(0, '0,  0,1,1,TX,0,59,   1, '0, 1, 3'b000, 58);
    add(0, '0,  1,0,0,'0,0,'0,   0, '0, 1, 3'b000, 59);
    add(0, '0,  1,1,0,'0,0,64'hE0E0_E0E0_E0E0_E0E0, 1, 64'hE0E0_E0E0_E0E0_E0E0, 1, 3'b000, 60);
    add(0, '0,  0,1,1,7'h05,0,'0, 1, 64'hE0E0_E0E0_E0E0_E0E0, 0, 3'b001, 60);
    add(0, '0,  0,1,1,TX,0,70,   1, 64'hE0E0_E0E0_E0E0_E0E0, 1, 3'b000, 60);
    add(0, '0,  1,0,0,'0,0,'0,   0, '0, 1, 3'b000, 61);
    add(1, 70,  0,0,0,'0,0,'0,   0, '0, 1, 3'b000, 70);
    add(0, '0,  1,1,0,'0,1,64'hE1E1_E1E1_E1E1_E1E1, 1, 64'hE1E1_E1E1_E1E1_E1E1, 0, 3'b000, 71);
    add(0, '0,  1,0,0,'0,0,'0,   1, '0, 0, 3'b000, 72);
    // wrap of the time counter; start time 0 fires on the wrapped slot
    add(1, 64'hFFFF_FFFF_FFFF_FFFE, 0,0,0,'0,0,'0, 0, '0, 0, 3'b000, 64'hFFFF_FFFF_FFFF_FFFE);
    add(0, '0,  1,0,0,'0,0,'0,   1, '0, 0, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF);
    add(0, '0,  1,0,0,'0,0,'0,   1, '0, 0, 3'b000, 0);
    add(0, '0,  0,1,1,TX,0,0,    1, '0, 1, 3'b000, 0);
    add(0, '0,  1,1,0,'0,1,64'hF0F0_0F0F_F0F0_0F0F, 1, 64'hF0F0_0F0F_F0F0_0F0F, 0, 3'b000, 1);
    add(0, '0,  1,0,0,'0,0,'0,   1, '0, 0, 3'b000, 2);
    // timed-only drop, untimed burst start, disable mid-burst
    c_to = 1;
    add(0, '0,  0,1,0,'0,0,64'h6060, 1, '0, 0, 3'b001, 2);
    c_to = 0;
    add(0, '0,  1,1,0,'0,0,64'h6161_0000_0000_6161, 1, 64'h6161_0000_0000_6161, 1, 3'b000, 3);
    c_en = 0;
    add(0, '0,  0,1,0,'0,0,64'h6262, 0, 64'h6161_0000_0000_6161, 0, 3'b000, 3);
    c_en = 1;
    add(0, '0,  1,0,0,'0,0,'0,   1, '0, 0, 3'b000, 4);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.en, v.drop, v.tonly, v.ld, v.ldv, v.stb, v.vld, v.tag, v.ty, v.last, v.d);
      #1;
      chk($sformatf("r%0d_ready", i), {63'd0, s_ready}, {63'd0, v.rdy});
      @(posedge dac_clk);
      #1;
      chk($sformatf("r%0d_data", i), dac_data_out, v.q);
      chk($sformatf("r%0d_time", i), sample_time, v.st);
      chk($sformatf("r%0d_flags", i), {60'd0, busy, underflow, late, proto_err},
          {60'd0, v.bsy, v.fl});
    end

    // untimed burst start, then reset in the middle of it
    drive(1, 0, 0, 0, '0, 1, 1, 0, '0, 0, 64'h7777_0000_0000_7777);
    @(posedge dac_clk); #1;
    chk("mid_data", dac_data_out, 64'h7777_0000_0000_7777);
    chk("mid_busy", {63'd0, busy}, 64'd1);
`ifdef RWT_DAC_SCHED_STATS_EN
    chk("stat_burst", {32'd0, burst_count}, 64'd6);
    chk("stat_late", {32'd0, late_count}, 64'd2);
    chk("stat_uf", {32'd0, underflow_count}, 64'd1);
`else
    chk("stat_all", {underflow_count | late_count, burst_count}, 64'd0);
`endif
    dac_rst = 1'b1;
    drive(1, 0, 0, 0, '0, 1, 1, 0, '0, 0, 64'h7878);
    @(posedge dac_clk); #1;
    chk("mrst_data", dac_data_out, 64'd0);
    chk("mrst_time", sample_time, 64'd0);
    chk("mrst_flags", {60'd0, busy, underflow, late, proto_err}, 64'd0);
    chk("mrst_counts", {underflow_count | late_count, burst_count}, 64'd0);
    dac_rst = 1'b0;
    drive(1, 0, 0, 0, '0, 0, 0, 0, '0, 0, '0);
    @(posedge dac_clk); #1;
    chk("post_busy", {63'd0, busy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
